// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave FSM state type for ahb_slave_if.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_WR = 3'd1,
        ST_DATA_RD = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } slv_state_t;

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end for a word-addressed register file.
// Define AHB_SLV_ERR_RESP_EN to enable the two-cycle ERROR response for illegal transfers.
//
// state      | meaning
// ST_IDLE    | no data phase in flight, zero-wait OKAY
// ST_DATA_WR | write data phase, rf_wr_en high, waits on rf_ready
// ST_DATA_RD | read data phase, rf_rd_en high, waits on rf_ready
// ST_ERR1    | first ERROR cycle (HREADYOUT low)
// ST_ERR2    | second ERROR cycle (HREADYOUT high)
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  rf_rd_en,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_ready,
    input  logic                  rf_error
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(REG_FILE_DEPTH);

    slv_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  legal_q, legal_d;

    htrans_t               htrans;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  legal;
    logic                  accept;
    logic                  unused_rf_error;

    assign htrans          = htrans_t'(HTRANS);
    assign word_idx        = {2'b00, HADDR[ADDR_WIDTH-1:2]};
    assign legal           = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00) && (word_idx < DEPTH_W);
    assign unused_rf_error = rf_error;

    assign rf_address = addr_q;
    assign rf_wr_data = HWDATA;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        legal_d   = legal_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        rf_rd_en  = 1'b0;
        rf_wr_en  = 1'b0;
        HRDATA    = '0;
        accept    = 1'b0;

        case (state_q)
            ST_DATA_WR: begin
                rf_wr_en  = write_q && legal_q;
                HREADYOUT = rf_ready;
            end
            ST_DATA_RD: begin
                rf_rd_en  = !write_q && legal_q;
                HREADYOUT = rf_ready;
                HRDATA    = rf_rd_data;
            end
`ifdef AHB_SLV_ERR_RESP_EN
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP     = HRESP_ERROR;
            end
`endif
            default: ;
        endcase

        // A new address phase is only taken when this slave is completing its data phase.
        accept = HSEL && HREADY && HREADYOUT && (htrans == NONSEQ || htrans == SEQ);

        if (accept) begin
            addr_d  = word_idx;
            write_d = HWRITE;
            legal_d = legal;
        end

`ifdef AHB_SLV_ERR_RESP_EN
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else
`endif
        if (HREADYOUT) begin
            if (accept && legal) begin
                state_d = HWRITE ? ST_DATA_WR : ST_DATA_RD;
            end else if (accept) begin
`ifdef AHB_SLV_ERR_RESP_EN
                state_d = ST_ERR1;
`else
                state_d = ST_IDLE;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            legal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            legal_q <= legal_d;
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed scoreboard bench for ahb_slave_if with a behavioural register file alongside it.
module tb_ahb_slave_if;
    import ahb_pkg::*;

`ifdef AHB_SLV_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        is_rd;
        logic [31:0] rdata;
        logic        resp;
        logic [7:0]  waits;
        logic [7:0]  wr_cnt;
        logic [31:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        rf_rd_en;
    logic        rf_wr_en;
    logic [31:0] rf_address;
    logic [31:0] rf_wr_data;
    logic [31:0] rf_rd_data;
    logic        rf_ready;
    logic        rf_error;

    logic [31:0] mem [16] = '{default: 32'h0};

    exp_t  sb[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    assign HREADY     = HREADYOUT;
    assign rf_rd_data = mem[rf_address[3:0]];

    always @(posedge clk) begin
        if (rf_wr_en && rf_ready) mem[rf_address[3:0]] <= rf_wr_data;
    end

    ahb_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_FILE_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .rf_rd_en   (rf_rd_en),
        .rf_wr_en   (rf_wr_en),
        .rf_address (rf_address),
        .rf_wr_data (rf_wr_data),
        .rf_rd_data (rf_rd_data),
        .rf_ready   (rf_ready),
        .rf_error   (rf_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic sel, input logic [1:0] trans, input logic w,
                       input logic [31:0] a, input logic [2:0] sz);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = w;
        HADDR  = a;
        HSIZE  = sz;
    endtask

    task automatic idle();
        bus(1'b0, IDLE, 1'b0, 32'h0, HSIZE_WORD);
    endtask

    task automatic push(input string tag, input logic is_rd, input logic [31:0] rdata,
                        input logic resp, input int waits, input int wr_cnt, input logic [31:0] idx);
        exp_t e;
        e.is_rd  = is_rd;
        e.rdata  = rdata;
        e.resp   = resp;
        e.waits  = 8'(waits);
        e.wr_cnt = 8'(wr_cnt);
        e.idx    = idx;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Follows the oldest outstanding data phase to completion and scores it.
    task automatic complete(input int stall);
        exp_t        e;
        string       tag;
        int          waits;
        int          wr_cnt;
        logic        resp_ok;
        logic        idx_ok;
        logic        excl_ok;
        logic        done;
        logic [31:0] rdata;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        tag = tag_q.pop_front();
        waits = 0; wr_cnt = 0; resp_ok = 1'b1; idx_ok = 1'b1; excl_ok = 1'b1;
        done = 1'b0; rdata = 32'h0;
        for (int c = 0; c < 20 && !done; c++) begin
            rf_ready = (c >= stall);
            @(negedge clk);
            if (HRESP !== e.resp) resp_ok = 1'b0;
            if (rf_wr_en === 1'b1) begin
                wr_cnt++;
                if (rf_address !== e.idx) idx_ok = 1'b0;
            end
            if (rf_rd_en === 1'b1 && rf_address !== e.idx) idx_ok = 1'b0;
            if (rf_rd_en === 1'b1 && rf_wr_en === 1'b1) excl_ok = 1'b0;
            if (HREADYOUT === 1'b1) begin
                done  = 1'b1;
                rdata = HRDATA;
            end else begin
                waits++;
                advance();
            end
        end
        rf_ready = 1'b1;
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_waits"}, 32'(waits), 32'(e.waits));
        check({tag, "_hresp"}, 32'(resp_ok), 32'd1);
        check({tag, "_wr_pulses"}, 32'(wr_cnt), 32'(e.wr_cnt));
        check({tag, "_rf_address"}, 32'(idx_ok), 32'd1);
        check({tag, "_strobe_excl"}, 32'(excl_ok), 32'd1);
        if (e.is_rd) check({tag, "_hrdata"}, rdata, e.rdata);
    endtask

    initial begin
        rst = 1'b1; rf_ready = 1'b1; rf_error = 1'b0; HWDATA = 32'h0;
        idle();
        advance();
        advance();
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_rf_rd_en", 32'(rf_rd_en), 32'd0);
        check("rst_hrdata", HRDATA, 32'h0);
        rst = 1'b0;
        advance();

        // Write 0x08 then read it back with no gap.
        bus(1'b1, NONSEQ, 1'b1, 32'h08, HSIZE_WORD);
        push("wr08", 1'b0, 32'h0, 1'b0, 0, 1, 32'd2);
        advance();
        HWDATA = 32'hDEADBEEF;
        bus(1'b1, NONSEQ, 1'b0, 32'h08, HSIZE_WORD);
        push("rd08", 1'b1, 32'hDEADBEEF, 1'b0, 0, 0, 32'd2);
        complete(0);
        advance();
        idle();
        complete(0);
        advance();

        // Index 16 is one past the end.
        bus(1'b1, NONSEQ, 1'b1, 32'h40, HSIZE_WORD);
        push("wr40", 1'b0, 32'h0, ERR_EN, ERR_EN ? 1 : 0, 0, 32'd16);
        advance();
        HWDATA = 32'hCAFEF00D;
        idle();
        complete(0);
        advance();

        bus(1'b1, NONSEQ, 1'b0, 32'h40, HSIZE_WORD);
        push("rd40", 1'b1, 32'h0, ERR_EN, ERR_EN ? 1 : 0, 0, 32'd16);
        advance();
        idle();
        complete(0);
        advance();

        bus(1'b1, NONSEQ, 1'b1, 32'h10, 3'b001);
        push("wr10_half", 1'b0, 32'h0, ERR_EN, ERR_EN ? 1 : 0, 0, 32'd4);
        advance();
        HWDATA = 32'h55555555;
        idle();
        complete(0);
        advance();

        bus(1'b1, NONSEQ, 1'b1, 32'h06, HSIZE_WORD);
        push("wr06_misalign", 1'b0, 32'h0, ERR_EN, ERR_EN ? 1 : 0, 0, 32'd1);
        advance();
        HWDATA = 32'h66666666;
        idle();
        complete(0);
        advance();

        bus(1'b1, NONSEQ, 1'b0, 32'h10, HSIZE_WORD);
        push("rd10_untouched", 1'b1, 32'h0, 1'b0, 0, 0, 32'd4);
        advance();
        idle();
        complete(0);
        advance();

        // Register file stalls the read for three cycles.
        bus(1'b1, NONSEQ, 1'b0, 32'h08, HSIZE_WORD);
        push("rd08_stall3", 1'b1, 32'hDEADBEEF, 1'b0, 3, 0, 32'd2);
        advance();
        idle();
        complete(3);
        advance();

        bus(1'b1, BUSY, 1'b0, 32'h08, HSIZE_WORD);
        push("busy_ignored", 1'b1, 32'h0, 1'b0, 0, 0, 32'd2);
        advance();
        idle();
        complete(0);
        advance();

        bus(1'b0, NONSEQ, 1'b0, 32'h08, HSIZE_WORD);
        push("unselected_ignored", 1'b1, 32'h0, 1'b0, 0, 0, 32'd2);
        advance();
        idle();
        complete(0);
        advance();

        // Last legal word, written and read back-to-back.
        bus(1'b1, NONSEQ, 1'b1, 32'h3C, HSIZE_WORD);
        push("wr3c", 1'b0, 32'h0, 1'b0, 0, 1, 32'd15);
        advance();
        HWDATA = 32'h0F0F0F0F;
        bus(1'b1, SEQ, 1'b0, 32'h3C, HSIZE_WORD);
        push("rd3c", 1'b1, 32'h0F0F0F0F, 1'b0, 0, 0, 32'd15);
        complete(0);
        advance();
        idle();
        complete(0);
        advance();

        // Reset lands in the middle of a stalled write to index 3.
        bus(1'b1, NONSEQ, 1'b1, 32'h0C, HSIZE_WORD);
        advance();
        HWDATA = 32'h12345678;
        idle();
        rf_ready = 1'b0;
        #1;
        check("midwr_rf_wr_en", 32'(rf_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check("midwr_rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("midwr_rst_hresp", 32'(HRESP), 32'd0);
        check("midwr_rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
        check("midwr_rst_rf_rd_en", 32'(rf_rd_en), 32'd0);
        check("midwr_rst_hrdata", HRDATA, 32'h0);
        rf_ready = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        advance();

        bus(1'b1, NONSEQ, 1'b0, 32'h0C, HSIZE_WORD);
        push("rd0c_after_rst", 1'b1, 32'h0, 1'b0, 0, 0, 32'd3);
        advance();
        idle();
        complete(0);
        advance();

        bus(1'b1, NONSEQ, 1'b0, 32'h08, HSIZE_WORD);
        push("rd08_after_rst", 1'b1, 32'hDEADBEEF, 1'b0, 0, 0, 32'd2);
        advance();
        idle();
        complete(0);
        advance();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
